// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between fetch and memory.
interface fetch_unit_if #(parameter int ADDR = 32);
  logic            req_valid;
  logic            req_ready;
  logic [ADDR-1:0] req_addr;
  logic            rsp_valid;
  logic [63:0]     rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: 2-wide fetch with credit-limited in-order imem requests and stale-response dropping.
module fetch_unit #(
  parameter int              ADDR            = 32,
  parameter logic [ADDR-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 2,
  parameter int              INST_WIDTH      = 32,
  parameter int              BP_GHR_BITS     = 8,
  parameter int              IF_BATCH_SIZE   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect_valid,
  input  logic [ADDR-1:0]          redirect_pc,
  fetch_unit_if.master             imem,
  output logic [ADDR-1:0]          bp_pc,
  input  logic                     bp_taken_0,
  input  logic                     bp_taken_1,
  input  logic [ADDR-1:0]          bp_target,
  input  logic [BP_GHR_BITS-1:0]   bp_hist,
  input  logic                     stall_in,
  output logic [IF_BATCH_SIZE-1:0] out_valid,
  output logic [INST_WIDTH-1:0]    out_inst_0,
  output logic [INST_WIDTH-1:0]    out_inst_1,
  output logic [ADDR-1:0]          out_pc_0,
  output logic [ADDR-1:0]          out_pc_1,
  output logic                     out_pred_taken_0,
  output logic                     out_pred_taken_1,
  output logic [ADDR-1:0]          out_pred_target_0,
  output logic [ADDR-1:0]          out_pred_target_1,
  output logic [BP_GHR_BITS-1:0]   out_pred_hist_0,
  output logic [BP_GHR_BITS-1:0]   out_pred_hist_1
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  typedef struct packed {
    logic [ADDR-1:0]        pc;
    logic                   t0;
    logic                   t1;
    logic [ADDR-1:0]        tgt;
    logic [BP_GHR_BITS-1:0] hist;
  } meta_t;
  meta_t       meta_q [MAX_OUTSTANDING];
  logic [63:0] data_q [MAX_OUTSTANDING];
  logic [ADDR-1:0] pc;
  logic [IW-1:0]   wp, fp, rp;
  logic [CW-1:0]   nl, nq, drop;
  logic            up, fire, pop, drop_rsp, fill, taken, has, two;
  meta_t           hd;
  logic [63:0]     hd_d;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    return (p == IW'(MAX_OUTSTANDING - 1)) ? '0 : p + IW'(1);
  endfunction
  assign hd       = meta_q[rp];
  assign hd_d     = data_q[rp];
  assign has      = nq != '0;
  assign two      = has && !hd.pc[2] && !hd.t0;
  assign pop      = |out_valid && !stall_in;
  assign drop_rsp = imem.rsp_valid && drop != '0;
  assign fill     = imem.rsp_valid && drop == '0 && nl != '0;
  assign taken    = bp_taken_0 || (!pc[2] && bp_taken_1);
  // A pop this cycle frees a queue slot, which keeps a 1-cycle memory streaming.
  assign imem.req_valid = up && !redirect_valid && (nl + drop + nq - CW'(pop) < CW'(MAX_OUTSTANDING));
  assign imem.req_addr  = up ? {pc[ADDR-1:3], 3'b0} : '0;
  assign bp_pc          = up ? pc : '0;
  assign fire           = imem.req_valid && imem.req_ready;
  always_comb begin
    out_valid         = (has && !redirect_valid) ? {two, 1'b1} : '0;
    out_inst_0        = has ? (hd.pc[2] ? hd_d[63:32] : hd_d[31:0]) : '0;
    out_inst_1        = two ? hd_d[63:32] : '0;
    out_pc_0          = has ? hd.pc : '0;
    out_pc_1          = two ? hd.pc + ADDR'(4) : '0;
    out_pred_taken_0  = has && hd.t0;
    out_pred_taken_1  = two && hd.t1;
    out_pred_target_0 = out_pred_taken_0 ? hd.tgt : '0;
    out_pred_target_1 = out_pred_taken_1 ? hd.tgt : '0;
    out_pred_hist_0   = has ? hd.hist : '0;
    out_pred_hist_1   = has ? hd.hist : '0;
  end
  always_ff @(posedge clk) begin
    if (fire) meta_q[wp] <= '{pc: pc, t0: bp_taken_0, t1: bp_taken_1, tgt: bp_target, hist: bp_hist};
    if (fill) data_q[fp] <= imem.rsp_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      up   <= 1'b0;
      wp   <= '0;
      fp   <= '0;
      rp   <= '0;
      nl   <= '0;
      nq   <= '0;
      drop <= '0;
    end else begin
      up <= 1'b1;
      if (redirect_valid) begin
        pc   <= redirect_pc;
        wp   <= '0;
        fp   <= '0;
        rp   <= '0;
        nl   <= '0;
        nq   <= '0;
        drop <= nl + drop - CW'(drop_rsp || fill);
      end else begin
        if (fire) pc <= taken ? bp_target : {pc[ADDR-1:3], 3'b0} + ADDR'(8);
        if (fire) wp <= inc(wp);
        if (fill) fp <= inc(fp);
        if (pop) rp <= inc(rp);
        nl   <= nl + CW'(fire) - CW'(fill);
        nq   <= nq + CW'(fill) - CW'(pop);
        drop <= drop - CW'(drop_rsp);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a 1-cycle in-order memory and a PC-matched predictor.
module tb_fetch_unit;
  logic        clk = 0, rst_n = 0, redirect_valid = 0, stall_in = 0, hold = 0;
  logic [31:0] redirect_pc = 0, t0_pc = 32'hFFFF_FFF0, bp_target = 0, bp_pc;
  logic        bp_taken_0, bp_taken_1;
  logic [7:0]  bp_hist;
  logic [1:0]  out_valid;
  logic [31:0] out_inst_0, out_inst_1, out_pc_0, out_pc_1, out_pred_target_0, out_pred_target_1;
  logic        out_pred_taken_0, out_pred_taken_1;
  logic [7:0]  out_pred_hist_0, out_pred_hist_1;
  logic [31:0] q[$], req_log[$], a;
  int          checks = 0, errors = 0, gap, base;
  fetch_unit_if imem();
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(imem),
    .bp_pc(bp_pc), .bp_taken_0(bp_taken_0), .bp_taken_1(bp_taken_1), .bp_target(bp_target), .bp_hist(bp_hist),
    .stall_in(stall_in), .out_valid(out_valid), .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
    .out_pc_0(out_pc_0), .out_pc_1(out_pc_1), .out_pred_taken_0(out_pred_taken_0),
    .out_pred_taken_1(out_pred_taken_1), .out_pred_target_0(out_pred_target_0),
    .out_pred_target_1(out_pred_target_1), .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1)
  );
  always #5 clk = ~clk;
  assign imem.req_ready = 1'b1;
  assign bp_taken_0 = bp_pc == t0_pc;
  assign bp_taken_1 = bp_pc + 32'd4 == t0_pc;
  assign bp_hist    = bp_pc[9:2];
  function automatic logic [31:0] word(input logic [31:0] x);
    return x ^ 32'hC0DE_0000;
  endfunction
  // Latency-1 memory: a request accepted at an edge is answered right after that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      imem.rsp_valid <= 1'b0;
      imem.rsp_data  <= '0;
    end else begin
      if (imem.req_valid && imem.req_ready) begin
        q.push_back(imem.req_addr);
        req_log.push_back(imem.req_addr);
      end
      if (!hold && q.size() > 0) begin
        a = q.pop_front();
        imem.rsp_valid <= 1'b1;
        imem.rsp_data  <= {word(a + 32'd4), word(a)};
      end else imem.rsp_valid <= 1'b0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic redir(input logic [31:0] p);
    redirect_pc = p;
    redirect_valid = 1'b1;
    cyc(1);
    redirect_valid = 1'b0;
  endtask
  // Waits (bounded) for a poppable bundle, checks every field, then steps past the pop.
  task automatic exp_b(input string tag, input logic [1:0] v, input logic [31:0] pc0,
                       input logic t0, input logic t1, input logic [31:0] tg, output int g);
    g = 0;
    while ((out_valid == 2'b00 || stall_in) && g < 20) begin
      cyc(1);
      g++;
    end
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".pc0"}, out_pc_0, pc0);
    chk({tag, ".inst0"}, out_inst_0, word(pc0));
    chk({tag, ".pc1"}, out_pc_1, v[1] ? pc0 + 32'd4 : 32'd0);
    chk({tag, ".inst1"}, out_inst_1, v[1] ? word(pc0 + 32'd4) : 32'd0);
    chk({tag, ".taken0"}, 32'(out_pred_taken_0), 32'(t0));
    chk({tag, ".taken1"}, 32'(out_pred_taken_1), 32'(t1));
    chk({tag, ".tgt0"}, out_pred_target_0, t0 ? tg : 32'd0);
    chk({tag, ".tgt1"}, out_pred_target_1, t1 ? tg : 32'd0);
    chk({tag, ".hist0"}, 32'(out_pred_hist_0), 32'(pc0[9:2]));
    chk({tag, ".hist1"}, 32'(out_pred_hist_1), 32'(pc0[9:2]));
    cyc(1);
  endtask
  initial begin
    cyc(2);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.req_valid", 32'(imem.req_valid), 0);
    chk("rst.bp_pc", bp_pc, 0);
    rst_n = 1'b1;
    exp_b("t1a", 2'b11, 32'h0, 0, 0, 0, gap);
    exp_b("t1b", 2'b11, 32'h8, 0, 0, 0, gap);
    chk("t1.gap", 32'(gap), 0);
    chk("t1.req0", req_log[0], 32'h0);
    chk("t1.req1", req_log[1], 32'h8);
    base = req_log.size();
    redirect_pc = 32'h104;
    redirect_valid = 1'b1;
    #1;
    chk("t2.redir_req", 32'(imem.req_valid), 0);
    chk("t2.redir_out", 32'(out_valid), 0);
    cyc(1);
    redirect_valid = 1'b0;
    exp_b("t2a", 2'b01, 32'h104, 0, 0, 0, gap);
    exp_b("t2b", 2'b11, 32'h108, 0, 0, 0, gap);
    chk("t2.req0", req_log[base], 32'h100);
    chk("t2.req1", req_log[base+1], 32'h108);
    t0_pc = 32'h20;
    bp_target = 32'h80;
    base = req_log.size();
    redir(32'h20);
    exp_b("t3a", 2'b01, 32'h20, 1, 0, 32'h80, gap);
    exp_b("t3b", 2'b11, 32'h80, 0, 0, 0, gap);
    chk("t3.req1", req_log[base+1], 32'h80);
    t0_pc = 32'h24;
    redir(32'h20);
    exp_b("t3c", 2'b11, 32'h20, 0, 1, 32'h80, gap);
    exp_b("t3d", 2'b11, 32'h80, 0, 0, 0, gap);
    t0_pc = 32'hFFFF_FFF0;
    stall_in = 1'b1;
    base = req_log.size();
    redir(32'h200);
    for (int k = 2; k <= 5; k++) begin
      cyc(1);
      if (k >= 3) begin
        chk("t4.stall_valid", 32'(out_valid), 3);
        chk("t4.stall_pc", out_pc_0, 32'h200);
      end
    end
    chk("t4.issued", 32'(req_log.size() - base), 2);
    stall_in = 1'b0;
    exp_b("t4a", 2'b11, 32'h200, 0, 0, 0, gap);
    chk("t4.gap", 32'(gap), 0);
    exp_b("t4b", 2'b11, 32'h208, 0, 0, 0, gap);
    exp_b("t4c", 2'b11, 32'h210, 0, 0, 0, gap);
    base = req_log.size();
    redir(32'h300);
    hold = 1'b1;
    cyc(3);
    chk("t5.credit", 32'(imem.req_valid), 0);
    chk("t5.issued", 32'(req_log.size() - base), 2);
    redir(32'h400);
    hold = 1'b0;
    exp_b("t5a", 2'b11, 32'h400, 0, 0, 0, gap);
    exp_b("t5b", 2'b11, 32'h408, 0, 0, 0, gap);
    stall_in = 1'b1;
    redir(32'h500);
    cyc(2);
    chk("t6.pre_valid", 32'(out_valid), 3);
    chk("t6.pre_rsp", 32'(imem.rsp_valid), 1);
    redirect_pc = 32'h600;
    redirect_valid = 1'b1;
    #1;
    chk("t6.redir_out", 32'(out_valid), 0);
    chk("t6.redir_req", 32'(imem.req_valid), 0);
    cyc(1);
    redirect_valid = 1'b0;
    stall_in = 1'b0;
    exp_b("t6a", 2'b11, 32'h600, 0, 0, 0, gap);
    rst_n = 1'b0;
    #1;
    chk("t6.rst_out", 32'(out_valid), 0);
    chk("t6.rst_req", 32'(imem.req_valid), 0);
    chk("t6.rst_bp_pc", bp_pc, 0);
    cyc(2);
    rst_n = 1'b1;
    base = req_log.size();
    exp_b("t6b", 2'b11, 32'h0, 0, 0, 0, gap);
    exp_b("t6c", 2'b11, 32'h8, 0, 0, 0, gap);
    chk("t6.req0", req_log[base], 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
